axi_master_bridge: RTL

//  CPU-side AXI4 master front-end. Turns single-word CPU load/store requests into single-beat AXI

---
 rtl/axi_master_bridge_pkg.sv | 33 +++
 rtl/axi_master_bridge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge_pkg.sv
// Shared AXI4 constants, widths and the bridge state encoding.
package axi_master_bridge_pkg;

  localparam int unsigned AxiIdBits    = 4;
  localparam int unsigned AxiAddrBits  = 32;
  localparam int unsigned AxiLenBits   = 4;
  localparam int unsigned AxiSizeBits  = 3;
  localparam int unsigned AxiBurstBits = 2;
  localparam int unsigned AxiDataBits  = 32;
  localparam int unsigned AxiStrbBits  = 4;
  localparam int unsigned AxiRespBits  = 2;

  localparam logic [AxiBurstBits-1:0] BurstIncr  = 2'b01;
  localparam logic [AxiSizeBits-1:0]  SizeWord   = 3'b010;
  localparam logic [AxiRespBits-1:0]  RespOkay   = 2'b00;
  localparam logic [AxiRespBits-1:0]  RespSlverr = 2'b10;
  localparam logic [AxiRespBits-1:0]  RespDecerr = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB,
    StDone
  } state_e;

  // Anything other than OKAY (including EXOKAY) is treated as a failure.
  function automatic logic resp_is_err(logic [AxiRespBits-1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// CPU load/store to single-beat AXI4 master bridge; stalls the CPU until the response completes.
// Optional AXI_MB_RESP_CHECK_EN: non-OKAY RRESP/BRESP sets a sticky cpu_err and zeroes failed loads.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter int unsigned MASTER_ID = 0,
  parameter bit          READ_ONLY = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [AxiAddrBits-1:0]  cpu_addr,
  input  logic [AxiDataBits-1:0]  cpu_wdata,
  input  logic [AxiStrbBits-1:0]  cpu_wstrb,
  output logic [AxiDataBits-1:0]  cpu_rdata,
  output logic                    cpu_stall,
  output logic                    cpu_done,
  output logic                    cpu_err,
  output logic [AxiIdBits-1:0]    arid,
  output logic [AxiAddrBits-1:0]  araddr,
  output logic [AxiLenBits-1:0]   arlen,
  output logic [AxiSizeBits-1:0]  arsize,
  output logic [AxiBurstBits-1:0] arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [AxiIdBits-1:0]    rid,
  input  logic [AxiDataBits-1:0]  rdata,
  input  logic [AxiRespBits-1:0]  rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [AxiIdBits-1:0]    awid,
  output logic [AxiAddrBits-1:0]  awaddr,
  output logic [AxiLenBits-1:0]   awlen,
  output logic [AxiSizeBits-1:0]  awsize,
  output logic [AxiBurstBits-1:0] awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AxiDataBits-1:0]  wdata,
  output logic [AxiStrbBits-1:0]  wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [AxiIdBits-1:0]    bid,
  input  logic [AxiRespBits-1:0]  bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  state_e                  state_q;
  logic [AxiAddrBits-1:0]  addr_q;
  logic [AxiDataBits-1:0]  wdata_q;
  logic [AxiStrbBits-1:0]  wstrb_q;
  logic                    aw_ok_q;
  logic                    w_ok_q;

  logic is_store;
  logic aw_hs;
  logic w_hs;
  logic unused_inputs;

  assign is_store = cpu_we & ~READ_ONLY;
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;

  // IDs are routed by the interconnect and single-beat reads always end with RLAST.
  assign unused_inputs = ^{rid, bid, rlast, rresp, bresp};

  assign cpu_stall = cpu_req & ~cpu_done;

  assign arid    = AxiIdBits'(MASTER_ID);
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = SizeWord;
  assign arburst = BurstIncr;
  assign awid    = AxiIdBits'(MASTER_ID);
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = SizeWord;
  assign awburst = BurstIncr;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

`ifndef AXI_MB_RESP_CHECK_EN
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
`ifdef AXI_MB_RESP_CHECK_EN
      cpu_err   <= 1'b0;
`endif
    end else begin
      cpu_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            if (is_store) begin
              state_q <= StWrAw;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_ok_q <= 1'b0;
              w_ok_q  <= 1'b0;
            end else begin
              state_q <= StRdA;
              arvalid <= 1'b1;
            end
          end
        end
        StRdA: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdD;
          end
        end
        StRdD: begin
          if (rvalid) begin
            rready   <= 1'b0;
            cpu_done <= 1'b1;
            state_q  <= StDone;
`ifdef AXI_MB_RESP_CHECK_EN
            if (resp_is_err(rresp)) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              cpu_rdata <= rdata;
            end
`else
            cpu_rdata <= rdata;
`endif
          end
        end
        StWrAw: begin
          // AW and W complete independently; each VALID drops right after its own handshake.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_ok_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_ok_q <= 1'b1;
          end
          if ((aw_ok_q | aw_hs) & (w_ok_q | w_hs)) begin
            bready  <= 1'b1;
            state_q <= StWrB;
          end
        end
        StWrB: begin
          if (bvalid) begin
            bready   <= 1'b0;
            cpu_done <= 1'b1;
            state_q  <= StDone;
`ifdef AXI_MB_RESP_CHECK_EN
            if (resp_is_err(bresp)) begin
              cpu_err <= 1'b1;
            end
`endif
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
